// File: rtl/pll_ctrl_pkg.sv
// ============================================================================
// Module   : pll_ctrl_pkg
// Brief    : Shared state encoding and parameter defaults for the PLL lock
//            controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pll_ctrl_pkg;

    localparam int unsigned c_DEF_RST_CYCLES          = 16;
    localparam int unsigned c_DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int unsigned c_DEF_LOCK_TIMEOUT_CYCLES = 65535;
    localparam int unsigned c_DEF_MAX_RETRIES         = 3;

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_RESET     = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_STABLE    = 3'd3,
        ST_READY     = 3'd4,
        ST_FAULT     = 3'd5
    } pll_state_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module   : sync_2ff
// Brief    : Two-flop synchronizer for a single-bit asynchronous input.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic r_meta_q;
    logic r_sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_meta_q <= 1'b0;
            r_sync_q <= 1'b0;
        end else begin
            r_meta_q <= d_i;
            r_sync_q <= r_meta_q;
        end
    end

    assign q_o = r_sync_q;

endmodule

`default_nettype wire

// File: rtl/pll_lock_ctrl.sv
// ============================================================================
// Module   : pll_lock_ctrl
// Brief    : PLL bring-up sequencer: reset pulse, lock wait with timeout,
//            lock stability qualification, retry/fault handling, ref select.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pll_lock_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned RST_CYCLES          = c_DEF_RST_CYCLES,
    parameter int unsigned LOCK_STABLE_CYCLES  = c_DEF_LOCK_STABLE_CYCLES,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = c_DEF_LOCK_TIMEOUT_CYCLES,
    parameter int unsigned MAX_RETRIES         = c_DEF_MAX_RETRIES,
    localparam int unsigned c_RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 sel_req_i,
    input  logic                 pll_lock_i,
    output logic                 pll_rst_o,
    output logic                 pll_sel_o,
    output logic                 clk_ready_o,
    output logic                 fault_o,
    output logic [c_RETRY_W-1:0] retry_cnt_o,
    output logic [2:0]           state_o
);

    localparam int unsigned c_CNT_W =
        $clog2(max3(RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES) + 1);

    localparam logic [c_CNT_W-1:0]   c_RST_LAST     = c_CNT_W'(RST_CYCLES - 1);
    localparam logic [c_CNT_W-1:0]   c_STABLE_LAST  = c_CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0]   c_TIMEOUT_LAST = c_CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [c_RETRY_W-1:0] c_RETRY_MAX    = c_RETRY_W'(MAX_RETRIES);

    pll_state_e           r_state_q, w_state_d;
    logic [c_CNT_W-1:0]   r_cnt_q, w_cnt_d;
    logic [c_RETRY_W-1:0] r_retry_q, w_retry_d;
    logic                 r_sel_q, w_sel_d;
    logic                 r_pll_rst_q;
    logic                 r_clk_ready_q;
    logic                 r_fault_q;
    logic                 w_lock_s;
    logic                 w_ref_chg;
    logic                 w_fail;

    sync_2ff u_lock_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (pll_lock_i),
        .q_o   (w_lock_s)
    );

    assign w_ref_chg = (sel_req_i != r_sel_q);

    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_retry_d = r_retry_q;
        w_sel_d   = r_sel_q;
        w_fail    = 1'b0;

        if (!en_i) begin
            w_state_d = ST_OFF;
            w_cnt_d   = '0;
            w_retry_d = '0;
        end else begin
            case (r_state_q)
                ST_OFF: begin
                    w_state_d = ST_RESET;
                    w_sel_d   = sel_req_i;
                    w_cnt_d   = '0;
                end
                // A reference change seen here waits until the pulse completes.
                ST_RESET: begin
                    if (r_cnt_q == c_RST_LAST) begin
                        w_state_d = ST_WAIT_LOCK;
                        w_cnt_d   = '0;
                    end else begin
                        w_cnt_d = r_cnt_q + c_CNT_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (!w_ref_chg) begin
                        if (w_lock_s) begin
                            w_state_d = ST_STABLE;
                            w_cnt_d   = '0;
                        end else if (r_cnt_q == c_TIMEOUT_LAST) begin
                            w_fail = 1'b1;
                        end else begin
                            w_cnt_d = r_cnt_q + c_CNT_W'(1);
                        end
                    end
                end
                ST_STABLE: begin
                    if (!w_ref_chg) begin
                        if (!w_lock_s) begin
                            w_state_d = ST_WAIT_LOCK;
                            w_cnt_d   = '0;
                        end else if (r_cnt_q == c_STABLE_LAST) begin
                            w_state_d = ST_READY;
                            w_cnt_d   = '0;
                        end else begin
                            w_cnt_d = r_cnt_q + c_CNT_W'(1);
                        end
                    end
                end
                ST_READY: begin
                    if (!w_ref_chg && !w_lock_s) begin
                        w_fail = 1'b1;
                    end
                end
                ST_FAULT: begin
                    w_state_d = ST_FAULT;
                end
                default: begin
                    w_state_d = ST_OFF;
                    w_cnt_d   = '0;
                end
            endcase

            // New reference restarts the whole bring-up with a fresh retry budget.
            if (w_ref_chg && (r_state_q == ST_WAIT_LOCK || r_state_q == ST_STABLE ||
                              r_state_q == ST_READY)) begin
                w_state_d = ST_RESET;
                w_sel_d   = sel_req_i;
                w_retry_d = '0;
                w_cnt_d   = '0;
            end else if (w_fail) begin
                w_cnt_d = '0;
                if (r_retry_q == c_RETRY_MAX) begin
                    w_state_d = ST_FAULT;
                end else begin
                    w_state_d = ST_RESET;
                    w_retry_d = r_retry_q + c_RETRY_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state_q     <= ST_OFF;
            r_cnt_q       <= '0;
            r_retry_q     <= '0;
            r_sel_q       <= 1'b0;
            r_pll_rst_q   <= 1'b1;
            r_clk_ready_q <= 1'b0;
            r_fault_q     <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_cnt_q       <= w_cnt_d;
            r_retry_q     <= w_retry_d;
            r_sel_q       <= w_sel_d;
            r_pll_rst_q   <= (w_state_d == ST_OFF) || (w_state_d == ST_RESET) ||
                             (w_state_d == ST_FAULT);
            r_clk_ready_q <= (w_state_d == ST_READY);
            r_fault_q     <= (w_state_d == ST_FAULT);
        end
    end

    assign pll_rst_o   = r_pll_rst_q;
    assign pll_sel_o   = r_sel_q;
    assign clk_ready_o = r_clk_ready_q;
    assign fault_o     = r_fault_q;
    assign retry_cnt_o = r_retry_q;
    assign state_o     = r_state_q;

endmodule

`default_nettype wire
